// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder block.
package spi_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } spi_state_e;

  localparam int unsigned SYNC_STAGES   = 2;
  // The system clock must run at least this many times faster than sclk.
  localparam int unsigned MIN_CLK_RATIO = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, followed by an edge register
// that emits one-cycle rise/fall ticks.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   rise_q;
  logic                   fall_q;

  // Reset to the pin's idle level so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{ResetVal}};
      last_q <= ResetVal;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      last_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~last_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & last_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave, MSB first: oversamples the SPI pins with clk, assembles
// received words and shifts out words from a one-deep transmit holding register.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              underrun,
  output logic              frame_err
);

  localparam int unsigned     CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(
    .ResetVal (1'b0)
  ) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(
    .ResetVal (1'b1)
  ) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mosi_sync_q <= '0;
    else      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [DATA_W-1:0] tx_hold_q, tx_hold_d;
  logic              tx_full_q, tx_full_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              rx_valid_q, rx_valid_d;
  logic              underrun_q, underrun_d;
  logic              frame_err_q, frame_err_d;
  logic              consume;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      tx_hold_q   <= '0;
      tx_full_q   <= 1'b0;
      tx_shift_q  <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      tx_hold_q   <= tx_hold_d;
      tx_full_q   <= tx_full_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    tx_hold_d   = tx_hold_q;
    tx_full_d   = tx_full_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    consume     = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d  = '0;
        miso_d = 1'b0;
        oe_d   = 1'b0;
        if (cs_fall) begin
          state_d = StActive;
          oe_d    = 1'b1;
          consume = 1'b1;
        end
      end
      StActive: begin
        // Deselect takes priority over any sclk tick in the same cycle.
        if (cs_rise) begin
          state_d    = StIdle;
          oe_d       = 1'b0;
          miso_d     = 1'b0;
          cnt_d      = '0;
          rx_shift_d = '0;
          if (cnt_q != '0) frame_err_d = 1'b1;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          if (cnt_q == CntLast) begin
            cnt_d      = '0;
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else if (sclk_fall) begin
          if (cnt_q != '0) begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_q[DATA_W-2];
          end else begin
            consume = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Word start: take the holding register, or send zeros and flag it.
    if (consume) begin
      if (tx_full_q) begin
        tx_shift_d = tx_hold_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
      miso_d = tx_shift_d[DATA_W-1];
    end

    // Evaluated after consume so a load racing an empty-register word start
    // is kept for the following word rather than bypassed into this one.
    if (tx_load && !tx_full_q) begin
      tx_hold_d = tx_data;
      tx_full_d = 1'b1;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = oe_q;
  assign tx_ready  = ~tx_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign underrun  = underrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: drives a mode-0 SPI master at clk/8.
module tb_spi_slave_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       tx_load = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso, miso_oe, tx_ready, rx_valid, underrun, frame_err;
  logic [7:0] rx_data;

  spi_slave_responder #(
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .underrun  (underrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int n_rxv = 0;
  int n_und = 0;
  int n_fe = 0;
  int rxv0, und0, fe0;
  logic [7:0] rx_log[$];
  logic [7:0] mi, mi1, mi2, d_tx, d_rx;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_rxv++;
      rx_log.push_back(rx_data);
    end
    if (underrun) n_und++;
    if (frame_err) n_fe++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pin_delay(input bit jit);
    if (jit) #($urandom_range(0, 4));
  endtask

  task automatic load(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic frame_begin(input bit jit);
    pin_delay(jit);
    cs_n = 1'b0;
    wait_cyc(6);
  endtask

  // Sends nb bits of mo MSB first; miso is sampled at the end of each high phase.
  // With last set, cs_n rises together with the final sclk fall.
  task automatic spi_bits(input logic [7:0] mo, input int nb, input bit last, input bit jit,
                          output logic [7:0] mo_in);
    mo_in = '0;
    for (int i = 0; i < nb; i++) begin
      pin_delay(jit);
      mosi = mo[7-i];
      wait_cyc(4);
      pin_delay(jit);
      sclk = 1'b1;
      wait_cyc(4);
      mo_in[7-i] = miso;
      pin_delay(jit);
      if (last && i == nb - 1) cs_n = 1'b1;
      sclk = 1'b0;
    end
  endtask

  initial begin
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(2);

    // Reset mid-word with cs_n low and the holding register full.
    load(8'h5A);
    frame_begin(0);
    spi_bits(8'hC3, 4, 0, 0, mi);
    load(8'h99);
    check("pre_reset_tx_ready", tx_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_err", frame_err, 0);
    wait_cyc(1);
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_cyc(2);
    rst = 1'b1;
    rxv0 = n_rxv;
    wait_cyc(12);
    #1;
    check("post_rst_no_rx_valid", n_rxv - rxv0, 0);
    check("post_rst_miso_oe", miso_oe, 0);
    check("post_rst_tx_ready", tx_ready, 1);

    // Single word.
    load(8'hA5);
    #1;
    check("load_tx_ready", tx_ready, 0);
    rxv0 = n_rxv;
    und0 = n_und;
    frame_begin(0);
    spi_bits(8'h3C, 8, 1, 0, mi);
    wait_cyc(8);
    #1;
    check("single_miso", mi, 8'hA5);
    check("single_rx_pulses", n_rxv - rxv0, 1);
    check("single_rx_data", rx_data, 8'h3C);
    check("single_no_underrun", n_und - und0, 0);
    check("single_miso_oe_off", miso_oe, 0);
    check("single_tx_ready", tx_ready, 1);

    // Back-to-back words in one frame.
    load(8'h12);
    rxv0 = n_rxv;
    und0 = n_und;
    frame_begin(0);
    load(8'h34);
    spi_bits(8'hF0, 8, 0, 0, mi1);
    spi_bits(8'h0F, 8, 1, 0, mi2);
    wait_cyc(8);
    #1;
    check("b2b_miso_w1", mi1, 8'h12);
    check("b2b_miso_w2", mi2, 8'h34);
    check("b2b_rx_pulses", n_rxv - rxv0, 2);
    check("b2b_rx_w1", rx_log[rx_log.size()-2], 8'hF0);
    check("b2b_rx_w2", rx_log[rx_log.size()-1], 8'h0F);
    check("b2b_no_underrun", n_und - und0, 0);

    // Underrun with a load landing in the same cycle as the word start.
    und0 = n_und;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tx_data = 8'h77;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    check("ur_pulse", underrun, 1);
    check("ur_tx_ready", tx_ready, 0);
    check("ur_miso_oe", miso_oe, 1);
    check("ur_miso", miso, 0);
    wait_cyc(4);
    spi_bits(8'h81, 8, 0, 0, mi1);
    spi_bits(8'h7E, 8, 1, 0, mi2);
    wait_cyc(8);
    #1;
    check("ur_miso_w1", mi1, 8'h00);
    check("ur_miso_w2", mi2, 8'h77);
    check("ur_count", n_und - und0, 1);
    check("ur_rx_data", rx_data, 8'h7E);

    // Frame error: deselect after five bits.
    load(8'hC3);
    rxv0 = n_rxv;
    fe0 = n_fe;
    frame_begin(0);
    spi_bits(8'hAA, 5, 0, 0, mi);
    wait_cyc(4);
    cs_n = 1'b1;
    wait_cyc(5);
    #1;
    check("fe_miso_oe", miso_oe, 0);
    check("fe_pulse", n_fe - fe0, 1);
    check("fe_no_rx_valid", n_rxv - rxv0, 0);
    check("fe_rx_data_held", rx_data, 8'h7E);
    check("fe_miso_bits", mi[7:3], 5'b11000);
    wait_cyc(4);

    // Random words with jittered pin timing.
    rxv0 = n_rxv;
    und0 = n_und;
    fe0 = n_fe;
    for (int k = 0; k < 300; k++) begin
      d_tx = 8'($urandom);
      d_rx = 8'($urandom);
      load(d_tx);
      frame_begin(1);
      spi_bits(d_rx, 8, 1, 1, mi);
      wait_cyc(6);
      #1;
      check("rnd_miso", mi, d_tx);
      check("rnd_rx", rx_log[$], d_rx);
    end
    check("rnd_rx_pulses", n_rxv - rxv0, 300);
    check("rnd_no_underrun", n_und - und0, 0);
    check("rnd_no_frame_err", n_fe - fe0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
